t08_instruction_fetch: RTL and testbench
========================================

# t08_instruction_fetch

Instruction fetch stage of the team 08 RV32I core. It owns the program counter and issues word fetches to the memory handler over a request/acknowledge handshake. It holds the fetched word stable on `instruction` for the control unit until the core signals the instruction has retired. On retire it selects the next PC: sequential (PC+4), or the jump/branch target when `jump` from the control unit or `branch_taken` from the ALU is asserted.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000. PC value loaded on reset.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `stall`  input  1  memory handler busy with a data load/store; suppresses the fetch request.
- `mem_instr_data`  input  32  instruction word returned by the memory handler.
- `mem_instr_ack`  input  1  memory handler has the fetch data; sampled only while `fetch_req` is high.
- `advance`  input  1  current instruction retired; sampled only in HOLD.
- `jump`  input  1  from the control unit; take `target` on retire.
- `branch_taken`  input  1  from the ALU; take `target` on retire.
- `target`  input  32  jump/branch destination computed by the ALU.
- `fetch_req`  output  1  fetch request to the memory handler.
- `fetch_addr`  output  32  fetch address; always equal to `pc`.
- `instruction`  output  32  latched instruction word, fed to the control unit.
- `instr_valid`  output  1  `instruction` is valid for the current `pc`.
- `pc`  output  32  address of the held or pending instruction.
- `pc_plus4`  output  32  `pc + 4`, used for the JAL/JALR link value.
- `misaligned`  output  1  target misalignment flag (see Configuration).

## Operation
- Two-state FSM: ISSUE and HOLD.
- ISSUE:
  - `fetch_req = !stall`.
  - If `fetch_req && mem_instr_ack`: latch `mem_instr_data` into `instruction`, set `instr_valid`, move to HOLD.
  - `advance`, `jump`, `branch_taken` and `target` are ignored.
- HOLD:
  - `fetch_req = 0`; `instruction` and `pc` are held stable.
  - `stall` and `mem_instr_ack` are ignored.
  - On `advance`: `pc` loads the next PC, `instr_valid` clears, FSM moves to ISSUE.
- Next PC selection:
  - If `jump | branch_taken`: `{target[31:2], 2'b00}`.
  - Otherwise: `pc + 4`.
  - Addition is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to `32'h0000_0000`.
- `pc_plus4` is combinational from `pc` and uses the same modulo arithmetic.
- Request withdrawal: if `stall` rises while ISSUE is waiting for an ack, `fetch_req` drops. An ack arriving in that cycle is discarded. The memory handler must accept a withdrawn request, and the fetch reissues to the same address once `stall` falls.
- Reset values:
  - FSM: ISSUE.
  - `pc`: `RESET_PC`.
  - `instruction`: 32'h0000_0000. This decodes to all enables low in the control unit.
  - `instr_valid`: 0.
  - `misaligned`: 0.
  - `fetch_req`: `!stall` (combinational).
- Reset asserted mid-fetch or mid-hold abandons the operation immediately; any pending ack is not captured.

## Timing
- `fetch_req` is combinational from the FSM state and `stall`. `fetch_addr` is registered (equals `pc`).
- Ack sampled at edge N → `instruction`/`instr_valid` valid after edge N; FSM is in HOLD from cycle N+1.
- `advance` sampled at edge M → new `pc` and `fetch_req` (if `!stall`) in cycle M+1.
- Minimum throughput: one instruction per 2 cycles (ack in the request cycle, `advance` in the first HOLD cycle).
- Simultaneous `jump` and `branch_taken`: `target` is used; the two are treated identically.

## Configuration
- Macro: `T08_FETCH_MISALIGN_EN`.
- Defined:
  - On `advance` with `jump|branch_taken` and `target[1:0] != 0`: `pc` is not updated, FSM stays in HOLD, `misaligned` is set.
  - `misaligned` is sticky until reset.
  - While `misaligned` is high, `advance` is ignored.
- Undefined:
  - `misaligned` is tied to 0.
  - Target low bits are silently cleared per the Next PC selection rule.

## Test plan
- Reset with `RESET_PC=32'h0000_0100`, `stall=0` → `pc=0x100`, `fetch_req=1`, `instr_valid=0`, `instruction=0`.
- Ack with data 32'h0050_0093 in the request cycle, then `advance` in the next cycle → `instruction=0x00500093` for one cycle; `pc=0x104` and `fetch_req=1` on the following cycle.
- In HOLD at `pc=0x104`: `advance` with `jump=1`, `target=0x0000_0200` → `pc=0x200`, `pc_plus4=0x204`. Repeat with `branch_taken=1`, `target=0x80` → `pc=0x80`.
- Raise `stall` for 3 cycles while ISSUE is waiting, pulsing `mem_instr_ack` during the stall → `fetch_req=0`, ack ignored, `instr_valid` stays 0; after `stall` falls, request resumes at the same `fetch_addr`.
- `pc=0xFFFF_FFFC`, sequential `advance` → `pc=0x0000_0000`. Assert `rst` during HOLD → `pc` returns to `RESET_PC` asynchronously and `instr_valid=0` without waiting for a clock edge.
- With `T08_FETCH_MISALIGN_EN` defined: `jump=1`, `target=0x202` → `misaligned=1`, `pc` unchanged, further `advance` ignored. Without the macro: `pc=0x200`, `misaligned=0`.

Source files
------------

// File: rtl/t08_instruction_fetch.sv
// Instruction fetch stage for the team 08 RV32I core: owns the PC and issues word fetches.
// Optional macro T08_FETCH_MISALIGN_EN traps misaligned jump/branch targets instead of masking.
module t08_instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] mem_instr_data,
  input  logic        mem_instr_ack,
  input  logic        advance,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] target,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  typedef enum logic {StIssue, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        redirect;
  logic [31:0] next_pc;

  assign redirect = jump | branch_taken;
  assign pc_plus4 = pc_q + 32'd4;
  assign next_pc  = redirect ? {target[31:2], 2'b00} : pc_plus4;

`ifdef T08_FETCH_MISALIGN_EN
  logic misaligned_q, misaligned_d;
  logic bad_target;

  assign bad_target = redirect && (target[1:0] != 2'b00);
`else
  // Low target bits are masked by next_pc; keep them visibly consumed.
  logic unused_target_lsb;
  assign unused_target_lsb = ^target[1:0];
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    fetch_req = 1'b0;
`ifdef T08_FETCH_MISALIGN_EN
    misaligned_d = misaligned_q;
`endif
    unique case (state_q)
      StIssue: begin
        // A stall withdraws the request, so an ack in that cycle is discarded.
        fetch_req = !stall;
        if (fetch_req && mem_instr_ack) begin
          instr_d = mem_instr_data;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
`ifdef T08_FETCH_MISALIGN_EN
        if (advance && !misaligned_q) begin
          if (bad_target) begin
            misaligned_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            valid_d = 1'b0;
            state_d = StIssue;
          end
        end
`else
        if (advance) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = StIssue;
        end
`endif
      end
      default: state_d = StIssue;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIssue;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef T08_FETCH_MISALIGN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_t08_instruction_fetch.sv
// Directed self-checking bench for t08_instruction_fetch with RESET_PC = 0x100.
module tb_t08_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] mem_instr_data;
  logic        mem_instr_ack;
  logic        advance;
  logic        jump;
  logic        branch_taken;
  logic [31:0] target;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int n_vec;
  int n_err;

  t08_instruction_fetch #(
    .RESET_PC(32'h0000_0100)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .mem_instr_data (mem_instr_data),
    .mem_instr_ack  (mem_instr_ack),
    .advance        (advance),
    .jump           (jump),
    .branch_taken   (branch_taken),
    .target         (target),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word from ISSUE with an immediate ack, ending in HOLD.
  task automatic fetch(input logic [31:0] data);
    mem_instr_ack  = 1'b1;
    mem_instr_data = data;
    tick();
    mem_instr_ack  = 1'b0;
  endtask

  // Retire the held instruction with the given redirect controls.
  task automatic retire(input logic j, input logic b, input logic [31:0] tgt);
    advance      = 1'b1;
    jump         = j;
    branch_taken = b;
    target       = tgt;
    tick();
    advance      = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    target       = 32'h0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; stall = 1'b0; mem_instr_data = 32'h0; mem_instr_ack = 1'b0;
    advance = 1'b0; jump = 1'b0; branch_taken = 1'b0; target = 32'h0;
    #2;
    check("rst_pc", pc, 32'h0000_0100);
    check("rst_fetch_req", {31'b0, fetch_req}, 32'd1);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    #1 rst = 1'b0;

    // Ack in the request cycle, advance in the first HOLD cycle.
    check("issue_addr", fetch_addr, 32'h0000_0100);
    fetch(32'h0050_0093);
    check("hold_instr", instruction, 32'h0050_0093);
    check("hold_valid", {31'b0, instr_valid}, 32'd1);
    check("hold_no_req", {31'b0, fetch_req}, 32'd0);
    retire(1'b0, 1'b0, 32'h0);
    check("seq_pc", pc, 32'h0000_0104);
    check("seq_req", {31'b0, fetch_req}, 32'd1);
    check("seq_valid", {31'b0, instr_valid}, 32'd0);
    check("seq_pc4", pc_plus4, 32'h0000_0108);

    // HOLD ignores ack and stalls; instruction stays put without advance.
    fetch(32'h0000_0013);
    mem_instr_ack = 1'b1; mem_instr_data = 32'hDEAD_BEEF; stall = 1'b1;
    tick();
    mem_instr_ack = 1'b0; stall = 1'b0;
    check("hold_keep_instr", instruction, 32'h0000_0013);
    check("hold_keep_pc", pc, 32'h0000_0104);

    // Jump then branch redirects.
    retire(1'b1, 1'b0, 32'h0000_0200);
    check("jump_pc", pc, 32'h0000_0200);
    check("jump_pc4", pc_plus4, 32'h0000_0204);
    fetch(32'h0000_0013);
    retire(1'b0, 1'b1, 32'h0000_0080);
    check("branch_pc", pc, 32'h0000_0080);

    // Stall withdraws the request; acks during the stall are dropped.
    tick();
    check("wait_req", {31'b0, fetch_req}, 32'd1);
    stall = 1'b1; mem_instr_ack = 1'b1; mem_instr_data = 32'h1111_1111;
    #1;
    check("stall_req", {31'b0, fetch_req}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("stall_valid", {31'b0, instr_valid}, 32'd0);
    stall = 1'b0; mem_instr_ack = 1'b0;
    #1;
    check("resume_req", {31'b0, fetch_req}, 32'd1);
    check("resume_addr", fetch_addr, 32'h0000_0080);
    fetch(32'h2222_2222);
    check("resume_instr", instruction, 32'h2222_2222);

    // Sequential wrap at the top of the address space.
    retire(1'b1, 1'b1, 32'hFFFF_FFFC);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_pc4", pc_plus4, 32'h0000_0000);
    fetch(32'h0000_0013);
    retire(1'b0, 1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0000_0000);

    // Asynchronous reset during HOLD.
    fetch(32'h3333_3333);
    #1 rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0000_0100);
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_instr", instruction, 32'h0);
    #1 rst = 1'b0;

    // Misaligned target handling.
    tick();
    fetch(32'h0000_0013);
    retire(1'b1, 1'b0, 32'h0000_0202);
`ifdef T08_FETCH_MISALIGN_EN
    check("mis_flag", {31'b0, misaligned}, 32'd1);
    check("mis_pc", pc, 32'h0000_0100);
    retire(1'b0, 1'b0, 32'h0);
    check("mis_adv_ignored", pc, 32'h0000_0100);
    check("mis_sticky", {31'b0, misaligned}, 32'd1);
`else
    check("mis_pc", pc, 32'h0000_0200);
    check("mis_flag", {31'b0, misaligned}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
